// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage
//   Decode stage of the LC-3 pipeline. Captures the fetched instruction word
//   and its NPC, then registers the execute, writeback and memory control
//   fields derived from the opcode. All outputs are registered.
//
// Ports
//   clock          in   1   single clock, posedge
//   reset          in   1   synchronous, active-high
//   enable_decode  in   1   capture and decode dout/npc_in this edge
//   flush          in   1   squash stage contents (branch redirect)
//   dout           in  16   instruction word from instruction memory
//   npc_in         in  16   PC+1 of that instruction
//   ir             out 16   registered instruction
//   npc_out        out 16   registered npc_in
//   E_control      out  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_control      out  2   writeback source: 00 ALU, 01 PC, 10 memory
//   mem_control    out  1   indirect memory access (LDI/STI)
//   decode_valid   out  1   stage holds a live decoded instruction
//   illegal_op     out  1   captured opcode is outside the supported set
module lc3_decode_stage #(
  parameter logic [15:0] NOP_IR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic        flush,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  E_control,
  output logic [1:0]  W_control,
  output logic        mem_control,
  output logic        decode_valid,
  output logic        illegal_op
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RSV  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_t;

  state_t  state;
  opcode_t opcode;

  logic [1:0] dec_alu;
  logic [1:0] dec_pcsel1;
  logic       dec_pcsel2;
  logic       dec_op2sel;
  logic [1:0] dec_w;
  logic       dec_mem;
  logic       dec_illegal;

  assign opcode       = opcode_t'(dout[15:12]);
  assign decode_valid = (state == FULL);

  // Opcode decode; unsupported opcodes leave every control field at zero.
  always_comb begin
    dec_alu     = '0;
    dec_pcsel1  = '0;
    dec_pcsel2  = 1'b0;
    dec_op2sel  = 1'b0;
    dec_w       = '0;
    dec_mem     = 1'b0;
    dec_illegal = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        dec_alu    = 2'b00;
        dec_op2sel = ~dout[5];
        dec_w      = 2'b00;
      end
      OP_AND: begin
        dec_alu    = 2'b01;
        dec_op2sel = ~dout[5];
        dec_w      = 2'b00;
      end
      OP_NOT: begin
        dec_alu = 2'b10;
        dec_w   = 2'b00;
      end
      OP_BR, OP_ST: begin
        dec_pcsel1 = 2'b01;
        dec_pcsel2 = 1'b1;
      end
      OP_LD: begin
        dec_pcsel1 = 2'b01;
        dec_pcsel2 = 1'b1;
        dec_w      = 2'b10;
      end
      OP_LDI: begin
        dec_pcsel1 = 2'b01;
        dec_pcsel2 = 1'b1;
        dec_w      = 2'b10;
        dec_mem    = 1'b1;
      end
      OP_STI: begin
        dec_pcsel1 = 2'b01;
        dec_pcsel2 = 1'b1;
        dec_mem    = 1'b1;
      end
      OP_LEA: begin
        dec_pcsel1 = 2'b01;
        dec_pcsel2 = 1'b1;
        dec_w      = 2'b01;
      end
      OP_LDR: begin
        dec_pcsel1 = 2'b10;
        dec_w      = 2'b10;
      end
      OP_STR: begin
        dec_pcsel1 = 2'b10;
      end
      OP_JMP: begin
        dec_pcsel1 = 2'b11;
      end
      OP_JSR, OP_RTI, OP_RSV, OP_TRAP: begin
        dec_illegal = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Flush clears exactly like reset and takes priority over a capture.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state       <= EMPTY;
      ir          <= NOP_IR;
      npc_out     <= '0;
      E_control   <= '0;
      W_control   <= '0;
      mem_control <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (enable_decode) begin
      state       <= FULL;
      ir          <= dout;
      npc_out     <= npc_in;
      E_control   <= {dec_alu, dec_pcsel1, dec_pcsel2, dec_op2sel};
      W_control   <= dec_w;
      mem_control <= dec_mem;
      illegal_op  <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_lc3_decode_stage.sv
module tb_lc3_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_decode = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] ir;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        mem_control;
  logic        decode_valid;
  logic        illegal_op;

  lc3_decode_stage #(.NOP_IR(16'h0000)) dut (
    .clock(clock),
    .reset(reset),
    .enable_decode(enable_decode),
    .flush(flush),
    .dout(dout),
    .npc_in(npc_in),
    .ir(ir),
    .npc_out(npc_out),
    .E_control(E_control),
    .W_control(W_control),
    .mem_control(mem_control),
    .decode_valid(decode_valid),
    .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        mem;
    logic        valid;
    logic        ill;
  } obs_t;

  obs_t exp_q[$];
  obs_t model;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic bit in_set(input logic [3:0] op, input logic [15:0] set_mask);
    return set_mask[op];
  endfunction

  // Reference: control fields from per-opcode membership sets.
  function automatic obs_t decode_ref(input logic [15:0] instr, input logic [15:0] npc);
    obs_t r;
    logic [3:0]  op;
    logic [15:0] alu_ops, off9, off6, zero_base, wb_pc, wb_mem, indirect, illegal;
    logic [1:0]  alu, pc1;
    logic        pc2, op2;
    op        = instr[15:12];
    alu_ops   = (16'h1 << 1) | (16'h1 << 5) | (16'h1 << 9);
    off9      = (16'h1 << 0) | (16'h1 << 2) | (16'h1 << 10) | (16'h1 << 3) | (16'h1 << 11) | (16'h1 << 14);
    off6      = (16'h1 << 6) | (16'h1 << 7);
    zero_base = (16'h1 << 12);
    wb_pc     = (16'h1 << 14);
    wb_mem    = (16'h1 << 2) | (16'h1 << 6) | (16'h1 << 10);
    indirect  = (16'h1 << 10) | (16'h1 << 11);
    illegal   = (16'h1 << 4) | (16'h1 << 8) | (16'h1 << 13) | (16'h1 << 15);
    alu = (op == 4'd5) ? 2'b01 : (op == 4'd9) ? 2'b10 : 2'b00;
    op2 = (op == 4'd1 || op == 4'd5) && !instr[5];
    pc1 = in_set(op, off9) ? 2'b01 : in_set(op, off6) ? 2'b10 : in_set(op, zero_base) ? 2'b11 : 2'b00;
    pc2 = in_set(op, off9);
    r.ir    = instr;
    r.npc   = npc;
    r.e     = {alu, pc1, pc2, op2};
    r.w     = in_set(op, wb_pc) ? 2'b01 : in_set(op, wb_mem) ? 2'b10 : 2'b00;
    r.mem   = in_set(op, indirect);
    r.valid = 1'b1;
    r.ill   = in_set(op, illegal);
    if (r.ill) begin
      r.e   = '0;
      r.w   = '0;
      r.mem = 1'b0;
    end
    if (in_set(op, alu_ops)) r.w = 2'b00;
    return r;
  endfunction

  task automatic apply(input bit rst, input bit fl, input bit en,
                       input logic [15:0] d, input logic [15:0] n);
    @(negedge clock);
    reset         = rst;
    flush         = fl;
    enable_decode = en;
    dout          = d;
    npc_in        = n;
    if (rst || fl) model = '0;
    else if (en)   model = decode_ref(d, n);
    exp_q.push_back(model);
  endtask

  // Monitor: compares whatever the DUT presents 1ns after each edge.
  initial begin
    obs_t exp_v, act;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act   = '{ir, npc_out, E_control, W_control, mem_control, decode_valid, illegal_op};
        vectors++;
        if (act !== exp_v) begin
          miscompares++;
          $display("FAIL vec%0d: got ir=%h npc=%h E=%b W=%b mem=%b valid=%b ill=%b, want ir=%h npc=%h E=%b W=%b mem=%b valid=%b ill=%b",
                   vectors, act.ir, act.npc, act.e, act.w, act.mem, act.valid, act.ill,
                   exp_v.ir, exp_v.npc, exp_v.e, exp_v.w, exp_v.mem, exp_v.valid, exp_v.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    model = '0;
    apply(1, 0, 1, 16'hFFFF, 16'h1234);
    apply(1, 0, 1, 16'hFFFF, 16'h1234);
    apply(0, 0, 1, 16'h1283, 16'h3001);
    apply(0, 0, 1, 16'h5265, 16'h3002);
    apply(0, 0, 1, 16'hA003, 16'h3003);
    apply(0, 0, 1, 16'h64C4, 16'h3004);
    apply(0, 0, 1, 16'hC1C0, 16'h3005);
    apply(0, 0, 1, 16'hE9FF, 16'h3006);
    apply(0, 0, 1, 16'h5220, 16'h3007);
    apply(0, 0, 1, 16'h927F, 16'h3008);
    apply(0, 0, 1, 16'h2005, 16'h3010);
    apply(0, 0, 0, 16'h1283, 16'h5555);
    apply(0, 0, 0, 16'hB00F, 16'hAAAA);
    apply(0, 0, 0, 16'hF025, 16'h0001);
    apply(0, 1, 1, 16'h1283, 16'h3011);
    apply(0, 0, 1, 16'h7040, 16'h3012);
    apply(1, 0, 1, 16'h1283, 16'h3013);
    apply(0, 0, 1, 16'hF025, 16'h4000);
    apply(0, 0, 1, 16'h1283, 16'h4001);
    apply(0, 0, 1, 16'h4ABC, 16'h4002);
    apply(0, 0, 1, 16'h8000, 16'h4003);
    apply(0, 0, 1, 16'hD123, 16'h4004);
    apply(0, 0, 1, 16'h0E02, 16'h4005);
    apply(0, 0, 1, 16'h3A01, 16'h4006);
    for (int unsigned i = 0; i < 400; i++) begin
      d = 16'($urandom);
      apply($urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 9) < 7, d, 16'($urandom));
    end
    apply(0, 0, 0, 16'h0000, 16'h0000);
    for (int unsigned i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never observed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
